// File: rtl/quad_decoder.sv
// quad_decoder: filtered quadrature decoder driving a wrapping position count
module quad_decoder #(
  parameter int WIDTH    = 8,
  parameter int FILT_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             up_down,
  output logic             step,
  output logic             err
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int AW = $clog2(FILT_LEN + 3);
  typedef enum logic {ARM, RUN} state_t;
  state_t state, state_n;
  logic [1:0] s1, s2, f, pp, qi, qp;
  logic [FW-1:0] run [2];
  logic [AW-1:0] arm_cnt;
  logic inc, dec, bad;
  // phases mapped onto positions 0..3 of the up sequence 00,10,11,01
  assign qi = {f[0], f[1] ^ f[0]};
  assign qp = {pp[0], pp[1] ^ pp[0]};
  always_comb begin
    state_n = (state == ARM && arm_cnt == AW'(FILT_LEN + 2)) ? RUN : state;
    inc = state == RUN && qi == qp + 2'd1;
    dec = state == RUN && qp == qi + 2'd1;
    bad = state == RUN && f == ~pp;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      f <= '0;
      run[0] <= '0;
      run[1] <= '0;
    end else begin
      s1 <= {a, b};
      s2 <= s1;
      // s1 is the value s2 takes on this edge, so the run counts edges s2 holds the new value
      for (int i = 0; i < 2; i++) begin
        if (s1[i] == f[i]) run[i] <= '0;
        else if (run[i] == FW'(FILT_LEN - 1)) begin
          f[i] <= s1[i];
          run[i] <= '0;
        end else run[i] <= (s2[i] != s1[i]) ? FW'(1) : run[i] + FW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ARM;
      arm_cnt <= '0;
      pp <= '0;
      count <= '0;
      up_down <= 1'b1;
      step <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ARM) arm_cnt <= arm_cnt + AW'(1);
      pp <= f;
      count <= clear ? '0 : inc ? count + WIDTH'(1) : dec ? count - WIDTH'(1) : count;
      up_down <= inc ? 1'b1 : dec ? 1'b0 : up_down;
      step <= inc | dec;
      err <= bad;
    end
  end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: table, directed and randomized checks of quad_decoder
module tb_quad_decoder;
  logic clk = 0, rst = 0, a = 0, b = 0, clear = 0;
  logic [7:0] count;
  logic up_down, step, err;
  int total = 0, passed = 0;
  logic [1:0] phases [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quad_decoder #(.WIDTH(8), .FILT_LEN(2)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .clear(clear),
    .count(count), .up_down(up_down), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] p;
    logic       clr;
    int         cnt;
    int         ud;
    int         steps;
    int         errs;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // apply a phase at a negedge, watch n edges, report pulses and the edge of the first step
  task automatic hold_phase(input logic [1:0] p, input int n, output int steps, output int errs, output int first);
    {a, b} = p;
    steps = 0;
    errs = 0;
    first = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (step) begin
        steps++;
        if (first < 0) first = i;
      end
      if (err) errs++;
    end
  endtask

  task automatic do_reset(input logic [1:0] p);
    @(negedge clk);
    {a, b} = p;
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_up_down", int'(up_down), 1);
    chk("rst_step", int'(step), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int st, er, fi, pos, ud, q, mv, hold, acc;
    tbl[0]  = '{2'b10, 1'b0, 1, 1, 1, 0};
    tbl[1]  = '{2'b11, 1'b0, 2, 1, 1, 0};
    tbl[2]  = '{2'b01, 1'b0, 3, 1, 1, 0};
    tbl[3]  = '{2'b00, 1'b0, 4, 1, 1, 0};
    tbl[4]  = '{2'b01, 1'b0, 3, 0, 1, 0};
    tbl[5]  = '{2'b11, 1'b0, 2, 0, 1, 0};
    tbl[6]  = '{2'b10, 1'b0, 1, 0, 1, 0};
    tbl[7]  = '{2'b00, 1'b0, 0, 0, 1, 0};
    tbl[8]  = '{2'b11, 1'b0, 0, 0, 0, 1};
    tbl[9]  = '{2'b01, 1'b0, 1, 1, 1, 0};
    tbl[10] = '{2'b00, 1'b0, 2, 1, 1, 0};
    tbl[11] = '{2'b11, 1'b0, 2, 1, 0, 1};
    tbl[12] = '{2'b00, 1'b0, 2, 1, 0, 1};
    tbl[13] = '{2'b00, 1'b1, 0, 1, 0, 0};

    do_reset(2'b00);
    // one-cycle glitch on a must be filtered out, then a double-bit jump flags err
    a = 1;
    @(negedge clk);
    a = 0;
    hold_phase(2'b00, 8, st, er, fi);
    chk("glitch_steps", st, 0);
    chk("glitch_errs", er, 0);
    chk("glitch_count", int'(count), 0);
    hold_phase(2'b11, 6, st, er, fi);
    chk("jump_errs", er, 1);
    chk("jump_steps", st, 0);
    chk("jump_count", int'(count), 0);
    hold_phase(2'b01, 6, st, er, fi);
    chk("after_jump_count", int'(count), 1);

    do_reset(2'b00);
    for (int i = 0; i < 14; i++) begin
      clear = tbl[i].clr;
      hold_phase(tbl[i].p, 6, st, er, fi);
      clear = 0;
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d_up_down", i), int'(up_down), tbl[i].ud);
      chk($sformatf("tbl%0d_steps", i), st, tbl[i].steps);
      chk($sformatf("tbl%0d_errs", i), er, tbl[i].errs);
      if (tbl[i].steps == 1) chk($sformatf("tbl%0d_latency", i), fi, 4);
    end

    pos = 0; ud = 1; q = 0;
    for (int i = 0; i < 150; i++) begin
      mv = $urandom_range(0, 3);
      hold = $urandom_range(4, 7);
      q = (q + (mv == 1 ? 1 : mv == 2 ? 3 : mv == 3 ? 2 : 0)) % 4;
      if (mv == 1) begin pos = (pos + 1) % 256; ud = 1; end
      if (mv == 2) begin pos = (pos + 255) % 256; ud = 0; end
      hold_phase(phases[q], hold, st, er, fi);
      chk($sformatf("rnd%0d_count", i), int'(count), pos);
      chk($sformatf("rnd%0d_up_down", i), int'(up_down), ud);
      chk($sformatf("rnd%0d_steps", i), st, (mv == 1 || mv == 2) ? 1 : 0);
      chk($sformatf("rnd%0d_errs", i), er, mv == 3 ? 1 : 0);
    end

    do_reset(2'b11);
    hold_phase(2'b01, 6, st, er, fi);
    chk("arm11_count", int'(count), 1);
    chk("arm11_errs", er, 0);
    chk("arm11_steps", st, 1);

    do_reset(2'b00);
    q = 0; acc = 0;
    for (int i = 0; i < 255; i++) begin
      q = (q + 1) % 4;
      hold_phase(phases[q], 4, st, er, fi);
      acc += st;
    end
    chk("pre_wrap_count", int'(count), 255);
    chk("pre_wrap_steps", acc, 255);
    q = (q + 1) % 4;
    hold_phase(phases[q], 6, st, er, fi);
    chk("wrap_up_count", int'(count), 0);
    chk("wrap_up_ud", int'(up_down), 1);
    q = (q + 3) % 4;
    hold_phase(phases[q], 6, st, er, fi);
    chk("wrap_down_count", int'(count), 255);
    chk("wrap_down_ud", int'(up_down), 0);

    // clear lands on the same edge as a down step
    q = (q + 3) % 4;
    {a, b} = phases[q];
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear = 1;
    @(posedge clk);
    @(negedge clk);
    chk("clear_count", int'(count), 0);
    chk("clear_step", int'(step), 1);
    chk("clear_ud", int'(up_down), 0);
    clear = 0;
    hold_phase(phases[q], 4, st, er, fi);
    chk("clear_no_defer", st, 0);
    q = (q + 3) % 4;
    hold_phase(phases[q], 6, st, er, fi);
    chk("post_clear_count", int'(count), 255);

    q = (q + 3) % 4;
    {a, b} = phases[q];
    repeat (2) @(negedge clk);
    do_reset(phases[q]);
    hold_phase(phases[q], 8, st, er, fi);
    chk("rearm_steps", st, 0);
    chk("rearm_count", int'(count), 0);
    q = (q + 1) % 4;
    hold_phase(phases[q], 6, st, er, fi);
    chk("rearm_run_count", int'(count), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
